// File: rtl/lsu_data_memory.sv
// lsu_data_memory: byte-addressable RV32 data memory with funct3-coded requests.
// Loads are sign- or zero-extended. Stores write byte lanes. Misaligned,
// out-of-range and illegal-funct3 requests come back with an error flag.
// Responses return in order through a valid/ready handshake.
// The read latency is configurable, and the number of outstanding requests
// is bounded.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   req_valid/ready     request handshake
//   req_write           1 = store, 0 = load
//   req_funct3          RISC-V funct3 (size + sign)
//   req_address         byte address
//   req_wdata           right-aligned store data
//   rsp_valid/ready     response handshake
//   rsp_rdata           extended load data, 0 for stores and errors
//   rsp_error           request was rejected
module lsu_data_memory #(
  parameter int unsigned ADDR_BITS       = 10,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = READ_LATENCY + 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned IDX_W = ADDR_BITS - 2;
  localparam int unsigned WORDS = 1 << IDX_W;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef struct packed {
    logic        error;
    logic [31:0] rdata;
  } rsp_t;

  // Storage: one byte per lane, four lanes per word
  logic [7:0] mem_q [WORDS][4];

  logic             accept;
  logic             pop;
  logic             sz_byte;
  logic             sz_half;
  logic             sz_word;
  logic             err_align;
  logic             err_range;
  logic             err_funct;
  logic             req_err;
  logic [IDX_W-1:0] word_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_word;
  logic [31:0]      rd_word;
  logic [31:0]      rd_shift;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;
  rsp_t             acc_rsp;

  logic [CNT_W-1:0] out_q;
  logic [CNT_W-1:0] out_d;

  logic             push_valid;
  rsp_t             push_data;

  rsp_t             fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [CNT_W-1:0] fcnt_q;
  logic [CNT_W-1:0] fcnt_d;
  rsp_t             head;

  // Handshakes; a pop frees its slot only from the next cycle on
  assign req_ready = !reset && (out_q < CNT_W'(MAX_OUTSTANDING));
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign word_idx  = req_address[ADDR_BITS-1:2];

  // Request decode and error classification
  always_comb begin
    sz_byte   = (req_funct3[1:0] == 2'b00);
    sz_half   = (req_funct3[1:0] == 2'b01);
    sz_word   = (req_funct3[1:0] == 2'b10);
    err_align = (sz_half && req_address[0]) ||
                (sz_word && (req_address[1:0] != 2'b00));
    err_range = ((req_address >> ADDR_BITS) != 32'd0);
    if (req_write) begin
      err_funct = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end else begin
      err_funct = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
    end
    req_err = err_align || err_range || err_funct;
  end

  // Store lane enables; data is replicated so each lane sees its own byte
  always_comb begin
    wr_be   = 4'b0000;
    wr_word = req_wdata;
    if (sz_byte) begin
      wr_be   = 4'b0001 << req_address[1:0];
      wr_word = {4{req_wdata[7:0]}};
    end else if (sz_half) begin
      wr_be   = req_address[1] ? 4'b1100 : 4'b0011;
      wr_word = {2{req_wdata[15:0]}};
    end else if (sz_word) begin
      wr_be   = 4'b1111;
    end
  end

  // Load lane select and extension
  always_comb begin
    rd_word  = {mem_q[word_idx][3], mem_q[word_idx][2],
                mem_q[word_idx][1], mem_q[word_idx][0]};
    rd_shift = rd_word >> {req_address[1:0], 3'b000};
    ld_byte  = rd_shift[7:0];
    ld_half  = req_address[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_funct3[1:0])
      2'b00:   ld_data = req_funct3[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = req_funct3[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase
    acc_rsp.error = req_err;
    acc_rsp.rdata = (req_err || req_write) ? 32'd0 : ld_data;
  end

  // Memory array: written at the accept edge, never reset
  always_ff @(posedge clock) begin
    if (accept && req_write && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_q[word_idx][b] <= wr_word[8*b +: 8];
        end
      end
    end
  end

  // Outstanding counter: accepted but not yet popped
  always_comb begin
    out_d = out_q;
    case ({accept, pop})
      2'b10:   out_d = out_q + CNT_W'(1);
      2'b01:   out_d = out_q - CNT_W'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  // Read pipeline: the accept edge is the first stage, READ_LATENCY-1 more follow
  if (READ_LATENCY == 1) begin : g_direct
    assign push_valid = accept;
    assign push_data  = acc_rsp;
  end else begin : g_pipe
    localparam int unsigned STAGES = READ_LATENCY - 1;

    logic [STAGES-1:0] vld_q;
    rsp_t              dat_q [STAGES];

    always_ff @(posedge clock) begin
      if (reset) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= accept;
        for (int i = 1; i < STAGES; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    always_ff @(posedge clock) begin
      dat_q[0] <= acc_rsp;
      for (int i = 1; i < STAGES; i++) begin
        dat_q[i] <= dat_q[i-1];
      end
    end

    assign push_valid = vld_q[STAGES-1];
    assign push_data  = dat_q[STAGES-1];
  end

  // Response FIFO pointers; depth equals the outstanding bound so it cannot overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (push_valid) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push_valid, pop})
      2'b10:   fcnt_d = fcnt_q + CNT_W'(1);
      2'b01:   fcnt_d = fcnt_q - CNT_W'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_valid && !reset) begin
      fifo_q[wr_ptr_q] <= push_data;
    end
  end

  // Head of FIFO drives the response; forced quiet while reset is high
  assign head      = fifo_q[rd_ptr_q];
  assign rsp_valid = !reset && (fcnt_q != '0);
  assign rsp_rdata = rsp_valid ? head.rdata : 32'd0;
  assign rsp_error = rsp_valid && head.error;

endmodule

// File: tb/tb_lsu_data_memory.sv
// Directed bench for lsu_data_memory: a READ_LATENCY=1 instance for function,
// errors and mid-flight reset, plus a READ_LATENCY=2 / MAX_OUTSTANDING=3
// instance for backpressure.
module tb_lsu_data_memory;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  logic        b_reset;
  logic        b_req_valid;
  logic        b_req_ready;
  logic        b_req_write;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_address;
  logic [31:0] b_req_wdata;
  logic        b_rsp_valid;
  logic        b_rsp_ready;
  logic [31:0] b_rsp_rdata;
  logic        b_rsp_error;

  int n_vec;
  int n_mis;

  lsu_data_memory #(.ADDR_BITS(10), .READ_LATENCY(1)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_funct3  (req_funct3),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error)
  );

  lsu_data_memory #(.ADDR_BITS(10), .READ_LATENCY(2), .MAX_OUTSTANDING(3)) u_dut_bp (
    .clock       (clock),
    .reset       (b_reset),
    .req_valid   (b_req_valid),
    .req_ready   (b_req_ready),
    .req_write   (b_req_write),
    .req_funct3  (b_req_funct3),
    .req_address (b_req_address),
    .req_wdata   (b_req_wdata),
    .rsp_valid   (b_rsp_valid),
    .rsp_ready   (b_rsp_ready),
    .rsp_rdata   (b_rsp_rdata),
    .rsp_error   (b_rsp_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request on the latency-1 instance; response checked right after the accept edge
  task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_data);
    @(negedge clock);
    req_valid   = 1'b1;
    req_write   = wr;
    req_funct3  = f3;
    req_address = addr;
    req_wdata   = wd;
    rsp_ready   = 1'b1;
    chk_eq({tag, "_rdy"}, 32'(req_ready), 32'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    chk_eq({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk_eq({tag, "_err"}, 32'(rsp_error), 32'(exp_err));
    chk_eq({tag, "_dat"}, rsp_rdata, exp_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      req_valid = 1'b0;
      @(posedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int r;
    logic rdy;
    logic [31:0] head0;

    n_vec = 0;
    n_mis = 0;
    reset = 1'b1;  b_reset = 1'b1;
    req_valid = 1'b0;  req_write = 1'b0;  req_funct3 = 3'd0;
    req_address = 32'd0;  req_wdata = 32'd0;  rsp_ready = 1'b1;
    b_req_valid = 1'b0;  b_req_write = 1'b0;  b_req_funct3 = 3'd0;
    b_req_address = 32'd0;  b_req_wdata = 32'd0;  b_rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_eq("rst_ready",  32'(req_ready), 32'd0);
    chk_eq("rst_valid",  32'(rsp_valid), 32'd0);
    chk_eq("rst_rdata",  rsp_rdata,      32'd0);
    chk_eq("rst_error",  32'(rsp_error), 32'd0);
    chk_eq("rst_ready2", 32'(b_req_ready), 32'd0);
    reset = 1'b0;  b_reset = 1'b0;

    // Store/load word
    do_req("sw10", 1'b1, 3'd2, 32'h10, 32'h12345678, 1'b0, 32'h0);
    do_req("lw10", 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h12345678);

    // Extension
    do_req("sw20",  1'b1, 3'd2, 32'h20, 32'h80FF7F01, 1'b0, 32'h0);
    do_req("lb23",  1'b0, 3'd0, 32'h23, 32'h0, 1'b0, 32'hFFFFFF80);
    do_req("lbu23", 1'b0, 3'd4, 32'h23, 32'h0, 1'b0, 32'h00000080);
    do_req("lh22",  1'b0, 3'd1, 32'h22, 32'h0, 1'b0, 32'hFFFF80FF);
    do_req("lhu22", 1'b0, 3'd5, 32'h22, 32'h0, 1'b0, 32'h000080FF);
    do_req("lb20",  1'b0, 3'd0, 32'h20, 32'h0, 1'b0, 32'h00000001);

    // Partial writes
    do_req("sw30", 1'b1, 3'd2, 32'h30, 32'h0, 1'b0, 32'h0);
    do_req("sb31", 1'b1, 3'd0, 32'h31, 32'hFFFFFFAA, 1'b0, 32'h0);
    do_req("sh32", 1'b1, 3'd1, 32'h32, 32'h1234BEEF, 1'b0, 32'h0);
    do_req("lw30", 1'b0, 3'd2, 32'h30, 32'h0, 1'b0, 32'hBEEFAA00);

    // Errors: none of these may touch memory
    do_req("lw11_mis",   1'b0, 3'd2, 32'h11,  32'h0, 1'b1, 32'h0);
    do_req("sh33_mis",   1'b1, 3'd1, 32'h33,  32'hFFFFFFFF, 1'b1, 32'h0);
    do_req("lw400_oor",  1'b0, 3'd2, 32'h400, 32'h0, 1'b1, 32'h0);
    do_req("ld_f3_3",    1'b0, 3'd3, 32'h30,  32'h0, 1'b1, 32'h0);
    do_req("st_f3_4",    1'b1, 3'd4, 32'h30,  32'hFFFFFFFF, 1'b1, 32'h0);
    do_req("lw30_after", 1'b0, 3'd2, 32'h30,  32'h0, 1'b0, 32'hBEEFAA00);

    // Backpressure instance: preload five words at 0x40..0x50
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      b_rsp_ready   = 1'b1;
      b_req_valid   = 1'b1;
      b_req_write   = 1'b1;
      b_req_funct3  = 3'd2;
      b_req_address = 32'h40 + 32'(4 * i);
      b_req_wdata   = 32'hA0000040 + 32'(4 * i);
      chk_eq($sformatf("bp_st%0d_rdy", i), 32'(b_req_ready), 32'd1);
      @(posedge clock);
    end
    @(negedge clock);
    b_req_valid = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk_eq("bp_st_drained", 32'(b_rsp_valid), 32'd0);

    // Five back-to-back loads with rsp_ready low: only three fit
    b_rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      b_req_valid   = 1'b1;
      b_req_write   = 1'b0;
      b_req_funct3  = 3'd2;
      b_req_address = 32'h40 + 32'(4 * k);
      rdy = b_req_ready;
      @(posedge clock);
      if (rdy) k++;
    end
    chk_eq("bp_accepted", 32'(k), 32'd3);
    @(negedge clock);
    chk_eq("bp_ready_low", 32'(b_req_ready), 32'd0);
    chk_eq("bp_head_vld",  32'(b_rsp_valid), 32'd1);
    chk_eq("bp_head_dat",  b_rsp_rdata, 32'hA0000040);
    head0 = b_rsp_rdata;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_eq("bp_hold_vld", 32'(b_rsp_valid), 32'd1);
    chk_eq("bp_hold_dat", b_rsp_rdata, head0);
    chk_eq("bp_hold_err", 32'(b_rsp_error), 32'd0);

    // Drain in order while the remaining two requests get in
    b_rsp_ready = 1'b1;
    r = 0;
    for (int c = 0; c < 40 && r < 5; c++) begin
      if (c != 0) @(negedge clock);
      if (k < 5) begin
        b_req_valid   = 1'b1;
        b_req_address = 32'h40 + 32'(4 * k);
      end else begin
        b_req_valid = 1'b0;
      end
      rdy = b_req_ready && b_req_valid;
      if (b_rsp_valid) begin
        chk_eq($sformatf("bp_drain%0d", r), b_rsp_rdata, 32'hA0000040 + 32'(4 * r));
        r++;
      end
      @(posedge clock);
      if (rdy) k++;
    end
    @(negedge clock);
    b_req_valid = 1'b0;
    chk_eq("bp_drain_cnt",   32'(r), 32'd5);
    chk_eq("bp_accept_cnt",  32'(k), 32'd5);

    // Reset mid-flight on the latency-1 instance
    idle(2);
    @(negedge clock);
    rsp_ready   = 1'b0;
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_funct3  = 3'd2;
    req_address = 32'h10;
    chk_eq("mf_rdy0", 32'(req_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    req_address = 32'h20;
    chk_eq("mf_rdy1", 32'(req_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    chk_eq("mf_full_rdy", 32'(req_ready), 32'd0);
    chk_eq("mf_full_vld", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk_eq("mf_rst_vld", 32'(rsp_valid), 32'd0);
    chk_eq("mf_rst_rdy", 32'(req_ready), 32'd0);
    chk_eq("mf_rst_dat", rsp_rdata,      32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk_eq("mf_post_rdy", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk_eq($sformatf("mf_stale%0d", i), 32'(rsp_valid), 32'd0);
      @(negedge clock);
    end
    do_req("mf_lw10", 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h12345678);
    do_req("mf_lw30", 1'b0, 3'd2, 32'h30, 32'h0, 1'b0, 32'hBEEFAA00);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
